// File: rtl/chip8_pkg.sv
// Shared encodings and width helpers for the CHIP-8 sprite blitter.
package chip8_pkg;

  localparam logic OP_DRAW  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_RD_ROW,
    ST_WRITE,
    ST_CLR,
    ST_DONE
  } state_t;

  // Bit width needed to index v items; never narrower than one bit.
  function automatic int log2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/chip8_row_merge.sv
// Combinational XOR merge of one sprite row into one VRAM row.
// The sprite is always 16 bits, MSB at column x0; narrow sprites leave the low byte zero.
module chip8_row_merge
  import chip8_pkg::*;
#(
  parameter int SCREEN_W = 64
) (
  input  logic [15:0]                  sprite,
  input  logic [log2w(SCREEN_W)-1:0]   x0,
  input  logic                         wrap,
  input  logic [SCREEN_W-1:0]          old_row,
  output logic [SCREEN_W-1:0]          new_row,
  output logic                         collision
);

  localparam int XW = log2w(SCREEN_W);

  logic [SCREEN_W-1:0] mask;

  // Place sprite pixels; truncating the column index gives wrap, the range test gives clip.
  always_comb begin
    mask = '0;
    for (int k = 0; k < 16; k++) begin
      if (sprite[15-k] && (wrap || (int'(x0) + k < SCREEN_W)))
        mask[XW'(int'(x0) + k)] = 1'b1;
    end
  end

  assign new_row   = old_row ^ mask;
  assign collision = |(old_row & mask);

endmodule

// File: rtl/chip8_blitter.sv
// Sprite draw / screen clear engine: reads sprite bytes from program RAM and
// XOR-merges them into VRAM rows, one read-modify-write per sprite row.
module chip8_blitter
  import chip8_pkg::*;
#(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32,
  parameter int RAM_LAT  = 2,
  parameter int VRAM_LAT = 2,
  parameter int WIDE_EN  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          op,
  input  logic                          wrap,
  input  logic [7:0]                    x_in,
  input  logic [7:0]                    y_in,
  input  logic [3:0]                    n_in,
  input  logic [11:0]                   i_in,
  output logic                          busy,
  output logic                          done,
  output logic                          collision,
  output logic [11:0]                   ram_address_out,
  input  logic [7:0]                    ram_data_in,
  output logic [log2w(SCREEN_H)-1:0]    vram_address_out,
  input  logic [SCREEN_W-1:0]           vram_data_in,
  output logic [SCREEN_W-1:0]           vram_data_out,
  output logic                          vram_write
);

  localparam int XW     = log2w(SCREEN_W);
  localparam int YW     = log2w(SCREEN_H);
  localparam int MAXLAT = (RAM_LAT > VRAM_LAT) ? RAM_LAT : VRAM_LAT;
  localparam int CW     = log2w(MAXLAT);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [4:0]          row_q, rows_q, row_nx;
  logic [XW-1:0]       x0_q;
  logic [YW-1:0]       y0_q;
  logic [11:0]         i_q;
  logic                wrap_q, wide_q;
  logic [15:0]         spr_q;
  logic [SCREEN_W-1:0] merge_row;
  logic                merge_coll, clip_now, clip_nx;

  assign row_nx   = row_q + 5'd1;
  // In clip mode a row below the screen ends the draw.
  assign clip_now = !wrap_q && (int'(y0_q) + int'(row_q)  >= SCREEN_H);
  assign clip_nx  = !wrap_q && (int'(y0_q) + int'(row_nx) >= SCREEN_H);

  chip8_row_merge #(.SCREEN_W(SCREEN_W)) u_merge (
    .sprite    (spr_q),
    .x0        (x0_q),
    .wrap      (wrap_q),
    .old_row   (vram_data_in),
    .new_row   (merge_row),
    .collision (merge_coll)
  );

  // Command FSM; all outputs registered, write strobe and data default low each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      row_q            <= '0;
      rows_q           <= '0;
      x0_q             <= '0;
      y0_q             <= '0;
      i_q              <= '0;
      wrap_q           <= 1'b0;
      wide_q           <= 1'b0;
      spr_q            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      collision        <= 1'b0;
      ram_address_out  <= '0;
      vram_address_out <= '0;
      vram_data_out    <= '0;
      vram_write       <= 1'b0;
    end else begin
      done          <= 1'b0;
      vram_write    <= 1'b0;
      vram_data_out <= '0;
      case (state)
        ST_IDLE: if (start) begin
          wrap_q    <= wrap;
          x0_q      <= XW'(x_in % SCREEN_W);
          y0_q      <= YW'(y_in % SCREEN_H);
          i_q       <= i_in;
          wide_q    <= (WIDE_EN != 0) && (n_in == 4'd0);
          rows_q    <= ((WIDE_EN != 0) && (n_in == 4'd0)) ? 5'd16 : {1'b0, n_in};
          row_q     <= '0;
          collision <= 1'b0;
          busy      <= 1'b1;
          if (op == OP_CLEAR) begin
            state            <= ST_CLR;
            vram_address_out <= '0;
            vram_write       <= 1'b1;
          end else if (n_in == 4'd0 && WIDE_EN == 0) begin
            state <= ST_DONE;
          end else begin
            state           <= ST_RD_HI;
            ram_address_out <= i_in;
            cnt             <= CW'(RAM_LAT - 1);
          end
        end
        ST_RD_HI: begin
          if (clip_now) state <= ST_DONE;
          else if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            spr_q[15:8] <= ram_data_in;
            if (wide_q) begin
              state           <= ST_RD_LO;
              ram_address_out <= ram_address_out + 12'd1;
              cnt             <= CW'(RAM_LAT - 1);
            end else begin
              spr_q[7:0]       <= 8'h00;
              state            <= ST_RD_ROW;
              vram_address_out <= y0_q + YW'(row_q);
              cnt              <= CW'(VRAM_LAT - 1);
            end
          end
        end
        ST_RD_LO: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            spr_q[7:0]       <= ram_data_in;
            state            <= ST_RD_ROW;
            vram_address_out <= y0_q + YW'(row_q);
            cnt              <= CW'(VRAM_LAT - 1);
          end
        end
        ST_RD_ROW: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            vram_data_out <= merge_row;
            vram_write    <= 1'b1;
            collision     <= collision | merge_coll;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          row_q <= row_nx;
          if (row_nx == rows_q) state <= ST_DONE;
          else begin
            // A clipped row is never fetched; RD_HI sees the clip and finishes.
            state <= ST_RD_HI;
            cnt   <= CW'(RAM_LAT - 1);
            if (!clip_nx) ram_address_out <= i_q + (12'(row_nx) << wide_q);
          end
        end
        ST_CLR: begin
          if (vram_address_out == YW'(SCREEN_H - 1)) state <= ST_DONE;
          else begin
            vram_address_out <= vram_address_out + 1'b1;
            vram_write       <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_blitter.sv
// Directed bench: 64x32 narrow instance plus a 128x64 wide-sprite instance,
// each with small RAM/VRAM models whose read latency matches the DUT wait.
module tb_chip8_blitter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start_a, start_b, op, wrap;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;

  logic         busy_a, done_a, coll_a, vwr_a;
  logic [11:0]  raddr_a;
  logic [7:0]   rdat_a;
  logic [4:0]   vaddr_a;
  logic [63:0]  vrd_a, vwd_a;

  logic         busy_b, done_b, coll_b, vwr_b;
  logic [11:0]  raddr_b;
  logic [7:0]   rdat_b;
  logic [5:0]   vaddr_b;
  logic [127:0] vrd_b, vwd_b;

  chip8_blitter dut_a (
    .clock(clock), .reset(reset), .start(start_a), .op(op), .wrap(wrap),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .busy(busy_a), .done(done_a), .collision(coll_a),
    .ram_address_out(raddr_a), .ram_data_in(rdat_a),
    .vram_address_out(vaddr_a), .vram_data_in(vrd_a),
    .vram_data_out(vwd_a), .vram_write(vwr_a)
  );

  chip8_blitter #(.SCREEN_W(128), .SCREEN_H(64), .RAM_LAT(2), .VRAM_LAT(2), .WIDE_EN(1)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .op(op), .wrap(wrap),
    .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
    .busy(busy_b), .done(done_b), .collision(coll_b),
    .ram_address_out(raddr_b), .ram_data_in(rdat_b),
    .vram_address_out(vaddr_b), .vram_data_in(vrd_b),
    .vram_data_out(vwd_b), .vram_write(vwr_b)
  );

  logic [7:0]   ram_a  [4096];
  logic [63:0]  vram_a [32];
  logic [7:0]   ram_b  [4096];
  logic [127:0] vram_b [64];

  int           cyc = 0;
  logic [4:0]   wa_addr[$];
  logic [63:0]  wa_data[$];
  int           wa_cyc[$];
  logic [5:0]   wb_addr[$];
  logic [127:0] wb_data[$];
  logic [11:0]  rb_seq[$];
  logic [11:0]  rb_prev = '0;

  // Memory models (one register stage = latency 2 as seen by the FSM) and write/address monitors.
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    rdat_a <= ram_a[raddr_a];
    vrd_a  <= vram_a[vaddr_a];
    rdat_b <= ram_b[raddr_b];
    vrd_b  <= vram_b[vaddr_b];
    if (vwr_a) begin
      vram_a[vaddr_a] <= vwd_a;
      wa_addr.push_back(vaddr_a);
      wa_data.push_back(vwd_a);
      wa_cyc.push_back(cyc);
    end
    if (vwr_b) begin
      vram_b[vaddr_b] <= vwd_b;
      wb_addr.push_back(vaddr_b);
      wb_data.push_back(vwd_b);
    end
    if (raddr_b != rb_prev) begin
      rb_seq.push_back(raddr_b);
      rb_prev <= raddr_b;
    end
  end

  int n_tot = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic vclr_a();
    foreach (vram_a[k]) vram_a[k] = '0;
  endtask

  // Issue one command to dut_a and return cycles from the start edge to done (-1 on timeout).
  // poke re-asserts start (as a CLEAR) two cycles in, which must be ignored.
  task automatic run_a(input logic o, input logic w, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] n, input logic [11:0] i, input bit poke,
                       output int lat, output logic b1);
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    @(negedge clock);
    op = o; wrap = w; x_in = x; y_in = y; n_in = n; i_in = i; start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    lat = -1;
    b1  = 1'b0;
    for (int m = 1; m <= 200; m++) begin
      @(posedge clock); #1;
      if (m == 1) b1 = busy_a;
      start_a = poke && (m == 2);
      if (start_a) op = 1'b1;
      if (done_a) begin
        lat = m;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  int   lat, bad;
  logic b1;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; op = 1'b0; wrap = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; i_in = '0;
    foreach (ram_a[k]) begin ram_a[k] = '0; ram_b[k] = '0; end
    vclr_a();
    foreach (vram_b[k]) vram_b[k] = '0;
    ram_a[12'h200] = 8'hF0;
    ram_a[12'h210] = 8'hFF;
    ram_a[12'h220] = 8'h80; ram_a[12'h221] = 8'h01;
    ram_a[12'h230] = 8'h80;
    ram_a[12'h240] = 8'h00; ram_a[12'h241] = 8'h20; ram_a[12'h242] = 8'h00;
    ram_a[12'h250] = 8'h80; ram_a[12'h251] = 8'h80;
    for (int k = 0; k < 32; k++) ram_b[12'h300 + k] = 8'hFF;

    repeat (3) @(posedge clock); #1;
    chk("rst_flags", 128'({busy_a, done_a, coll_a, vwr_a}), 128'h0);
    chk("rst_raddr", 128'(raddr_a), 128'h0);
    chk("rst_vaddr", 128'(vaddr_a), 128'h0);
    chk("rst_vdata", 128'(vwd_a), 128'h0);
    reset = 1'b0;

    // basic draw on empty VRAM
    run_a(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, lat, b1);
    chk("basic_lat",  128'(lat), 128'd6);
    chk("basic_busy", 128'(b1), 128'd1);
    chk("basic_nwr",  128'(wa_addr.size()), 128'd1);
    chk("basic_row",  128'(wa_addr[0]), 128'd0);
    chk("basic_data", 128'(wa_data[0]), 128'hF);
    chk("basic_coll", 128'(coll_a), 128'd0);

    // same command again, started in the done cycle: erases and collides
    run_a(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, lat, b1);
    chk("redraw_lat",  128'(lat), 128'd6);
    chk("redraw_data", 128'(wa_data[0]), 128'h0);
    chk("redraw_coll", 128'(coll_a), 128'd1);

    // n==0 without wide support: nothing touched, collision cleared
    run_a(1'b0, 1'b1, 8'd5, 8'd5, 4'd0, 12'h200, 1'b0, lat, b1);
    chk("n0_lat",  128'(lat), 128'd1);
    chk("n0_nwr",  128'(wa_addr.size()), 128'd0);
    chk("n0_coll", 128'(coll_a), 128'd0);

    // horizontal wrap and clip
    vclr_a();
    run_a(1'b0, 1'b1, 8'd62, 8'd3, 4'd1, 12'h210, 1'b0, lat, b1);
    chk("hwrap_row",  128'(wa_addr[0]), 128'd3);
    chk("hwrap_data", 128'(wa_data[0]), 128'hC00000000000003F);
    vclr_a();
    run_a(1'b0, 1'b0, 8'd62, 8'd3, 4'd1, 12'h210, 1'b0, lat, b1);
    chk("hclip_data", 128'(wa_data[0]), 128'hC000000000000000);

    // vertical wrap and clip
    vclr_a();
    run_a(1'b0, 1'b1, 8'd4, 8'd31, 4'd2, 12'h220, 1'b0, lat, b1);
    chk("vwrap_lat",   128'(lat), 128'd11);
    chk("vwrap_nwr",   128'(wa_addr.size()), 128'd2);
    chk("vwrap_row0",  128'(wa_addr[0]), 128'd31);
    chk("vwrap_row1",  128'(wa_addr[1]), 128'd0);
    chk("vwrap_data0", 128'(wa_data[0]), 128'h10);
    chk("vwrap_data1", 128'(wa_data[1]), 128'h800);
    vclr_a();
    run_a(1'b0, 1'b0, 8'd4, 8'd31, 4'd2, 12'h220, 1'b0, lat, b1);
    chk("vclip_lat",    128'(lat), 128'd7);
    chk("vclip_nwr",    128'(wa_addr.size()), 128'd1);
    chk("vclip_row",    128'(wa_addr[0]), 128'd31);
    chk("vclip_noread", 128'(raddr_a), 128'h220);

    // coordinates taken modulo the screen size
    vclr_a();
    run_a(1'b0, 1'b0, 8'd70, 8'd33, 4'd1, 12'h230, 1'b0, lat, b1);
    chk("mod_lat",  128'(lat), 128'd6);
    chk("mod_row",  128'(wa_addr[0]), 128'd1);
    chk("mod_data", 128'(wa_data[0]), 128'h40);

    // three rows, middle one collides with a preset pixel
    vclr_a();
    vram_a[5] = 64'h4;
    run_a(1'b0, 1'b0, 8'd0, 8'd4, 4'd3, 12'h240, 1'b0, lat, b1);
    chk("multi_lat",   128'(lat), 128'd16);
    chk("multi_nwr",   128'(wa_addr.size()), 128'd3);
    chk("multi_row1",  128'(wa_addr[1]), 128'd5);
    chk("multi_data1", 128'(wa_data[1]), 128'h0);
    chk("multi_coll",  128'(coll_a), 128'd1);

    // clear: 32 back-to-back zero writes
    foreach (vram_a[k]) vram_a[k] = {32'hDEADBEEF, 32'(k)};
    run_a(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0, lat, b1);
    chk("clr_lat",  128'(lat), 128'd33);
    chk("clr_nwr",  128'(wa_addr.size()), 128'd32);
    bad = 0;
    for (int k = 0; k < wa_addr.size(); k++)
      if (wa_addr[k] != 5'(k) || wa_data[k] != '0 || (k > 0 && wa_cyc[k] != wa_cyc[k-1] + 1)) bad++;
    chk("clr_seq",  128'(bad), 128'd0);
    chk("clr_coll", 128'(coll_a), 128'd0);

    // start while busy is ignored
    vclr_a();
    run_a(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200, 1'b1, lat, b1);
    chk("poke_lat",  128'(lat), 128'd6);
    chk("poke_nwr",  128'(wa_addr.size()), 128'd1);
    chk("poke_data", 128'(wa_data[0]), 128'hF);

    // reset during RD_ROW of row 1
    vclr_a();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    @(negedge clock);
    op = 1'b0; wrap = 1'b1; x_in = 8'd0; y_in = 8'd0; n_in = 4'd2; i_in = 12'h250; start_a = 1'b1;
    @(posedge clock); #1 start_a = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_flags", 128'({busy_a, done_a, coll_a, vwr_a}), 128'h0);
    chk("rstmid_raddr", 128'(raddr_a), 128'h0);
    chk("rstmid_vaddr", 128'(vaddr_a), 128'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rstmid_nwr",  128'(wa_addr.size()), 128'd1);
    chk("rstmid_row0", 128'(vram_a[0]), 128'h1);
    chk("rstmid_row1", 128'(vram_a[1]), 128'h0);

    // start on the first edge after reset release
    vclr_a();
    run_a(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, lat, b1);
    chk("postrst_lat",  128'(lat), 128'd6);
    chk("postrst_data", 128'(wa_data[0]), 128'hF);

    // wide 16x16 sprite on the 128x64 instance, wrapping vertically
    wb_addr.delete(); wb_data.delete(); rb_seq.delete();
    @(negedge clock);
    op = 1'b0; wrap = 1'b1; x_in = 8'd10; y_in = 8'd60; n_in = 4'd0; i_in = 12'h300; start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    lat = -1;
    for (int m = 1; m <= 300; m++) begin
      @(posedge clock); #1;
      if (done_b) begin
        lat = m;
        break;
      end
    end
    chk("wide_lat", 128'(lat), 128'd113);
    chk("wide_nwr", 128'(wb_addr.size()), 128'd16);
    bad = 0;
    for (int k = 0; k < wb_addr.size(); k++)
      if (wb_addr[k] != 6'(60 + k) || wb_data[k] != 128'h3FFFC00) bad++;
    chk("wide_rows", 128'(bad), 128'd0);
    chk("wide_nrd",  128'(rb_seq.size()), 128'd32);
    bad = 0;
    for (int k = 0; k < rb_seq.size(); k++)
      if (rb_seq[k] != 12'h300 + 12'(k)) bad++;
    chk("wide_rdseq", 128'(bad), 128'd0);
    chk("wide_coll",  128'(coll_b), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
